// File: rtl/rv_pkg.sv
// rv_pkg: RV64 widths, opcode field slice and major opcodes shared by fetch and control.
package rv_pkg;
    localparam int XLEN    = 64;
    localparam int ILEN    = 32;
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] i);
        return i[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/if_inst_fifo.sv
// if_inst_fifo: power-of-two instruction buffer with flush; empty drives zero data.
module if_inst_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 96,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop, do_push;
    always_comb begin
        empty   = count == '0;
        full    = count == CW'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = empty ? '0 : mem[rd_ptr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && !do_push)) else $error("if_inst_fifo: push while full");
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: credit-limited in-order instruction fetch with redirect flush and stale-response dropping.
module if_fetch_unit
    import rv_pkg::*;
#(
    parameter int               XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0]      fetch_pc, rsp_pc, target;
    logic [CW-1:0]        outstanding, drop_cnt, fifo_count, out_next;
    logic                 full, empty, accept, rsp_ok, keep, pop;
    logic [XLEN+ILEN-1:0] head;
    always_comb begin
        target         = redirect_pc & ~XLEN'(3);
        imem_req_valid = rst_n && !full && !redirect_valid
                         && ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        // a response with nothing outstanding can only be a leftover from before reset
        rsp_ok         = imem_rsp_valid && outstanding != '0;
        keep           = rsp_ok && drop_cnt == '0 && !redirect_valid;
        pop            = !empty && !stall && !redirect_valid;
        out_next       = outstanding + CW'(accept) - CW'(rsp_ok);
        inst_valid     = !empty;
        inst           = head[ILEN-1:0];
        inst_pc        = head[XLEN+ILEN-1:ILEN];
        opcode         = opcode_of(inst);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= out_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (keep) rsp_pc <= rsp_pc + XLEN'(4);
                if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end
    if_inst_fifo #(.DEPTH(DEPTH), .W(XLEN + ILEN)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .wdata ({rsp_pc, imem_rsp_data}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch scenarios against a 1-cycle memory model and a PC/instruction scoreboard.
module tb_if_fetch_unit;
    logic        clk = 0, rst_n = 0;
    logic        imem_req_valid, imem_req_ready = 1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [6:0]  opcode;
    int n_cmp = 0, n_err = 0;
    typedef struct { logic [63:0] pc; logic [31:0] d; } ent_t;
    typedef struct { logic [63:0] a; bit stale; } mq_t;
    ent_t sb[$];
    mq_t  mq[$];
    logic [63:0] exp_fetch = '0;
    bit mem_en = 1;

    if_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return 32'h13 | {a[24:0], 7'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive one cycle at the negedge, check outputs, then account for the coming posedge
    task automatic step(input bit st, input bit rd, input logic [63:0] rpc);
        bit rv, acc;
        mq_t m;
        stall = st;
        redirect_valid = rd;
        redirect_pc = rpc;
        rv = mem_en && mq.size() != 0;
        if (rv) begin
            m = mq.pop_front();
            imem_rsp_valid = 1;
            imem_rsp_data = inst_of(m.a);
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data = '0;
        end
        #1;
        chk("inst_valid", inst_valid, 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("inst_pc", inst_pc, sb[0].pc);
            chk("inst", inst, sb[0].d);
            chk("opcode", opcode, sb[0].d[6:0]);
        end else begin
            chk("inst_empty", {inst_pc[31:0], inst}, 64'h0);
        end
        acc = imem_req_valid && imem_req_ready;
        if (rd) chk("req_in_redirect", imem_req_valid, 0);
        if (acc) begin
            chk("req_addr", imem_req_addr, exp_fetch);
            mq.push_back('{exp_fetch, 1'b0});
            exp_fetch += 4;
        end
        if (rd) begin
            sb.delete();
            foreach (mq[i]) mq[i].stale = 1;
            exp_fetch = rpc & ~64'h3;
        end else begin
            if (sb.size() != 0 && !st) void'(sb.pop_front());
            if (rv && !m.stale) sb.push_back('{m.a, inst_of(m.a)});
        end
        @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 12 && !inst_valid; i++) step(0, 0, 0);
        chk("wait_valid", inst_valid, 1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", inst_valid, 0);
        chk("rst_req", imem_req_valid, 0);
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("first_valid_c2", inst_valid, 1);
        chk("first_pc", inst_pc, 64'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("stall_no_req", imem_req_valid, 0);
        chk("stall_head", inst_pc, 64'h0);
        chk("stall_two_req", exp_fetch, 64'h8);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        mem_en = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("two_in_flight", 64'(mq.size()), 64'd2);
        chk("credits_used", imem_req_valid, 0);
        step(0, 1, 64'h100);
        mem_en = 1;
        wait_valid();
        chk("redir_pc_100", inst_pc, 64'h100);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(0, 1, 64'h203);
        wait_valid();
        chk("redir_pc_200", inst_pc, 64'h200);
        for (int i = 0; i < 5 && mq.size() == 0; i++) step(0, 0, 0);
        chk("rsp_pending", 64'(mq.size() != 0), 64'd1);
        step(1, 1, 64'h300);
        chk("flush_empty", inst_valid, 0);
        wait_valid();
        chk("redir_pc_300", inst_pc, 64'h300);
        mem_en = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        rst_n = 0;
        sb.delete();
        foreach (mq[i]) mq[i].stale = 1;
        exp_fetch = 64'h0;
        #1;
        chk("rst_mid_valid", inst_valid, 0);
        chk("rst_mid_out", {inst_pc[31:0], inst}, 64'h0);
        chk("rst_mid_opc", opcode, 0);
        chk("rst_mid_req", imem_req_valid, 0);
        @(negedge clk);
        mem_en = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        rst_n = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("restart_valid", inst_valid, 1);
        chk("restart_pc", inst_pc, 64'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
